// File: rtl/mult_pkg.sv
// Shared types for the add-shift multiplier: datapath op encoding, controller states, width.
package mult_pkg;

   localparam int unsigned MULT_N_BITS = 8;

   typedef enum logic [2:0] {
      OP_CLR_LD = 3'b000,
      OP_HOLD   = 3'b001,
      OP_ADD    = 3'b010,
      OP_SUB    = 3'b011,
      OP_SAVE   = 3'b100,
      OP_SHIFT  = 3'b101,
      OP_START  = 3'b110
   } op_t;

   typedef enum logic [2:0] {
      S_WAIT_REL = 3'd0,
      S_IDLE     = 3'd1,
      S_CLR      = 3'd2,
      S_START    = 3'd3,
      S_ARITH    = 3'd4,
      S_SHIFT    = 3'd5,
      S_SAVE     = 3'd6,
      S_HALT     = 3'd7
   } state_t;

endpackage

// File: rtl/mult_seq_control_if.sv
// Button/datapath/status bundle between the multiplier top level and its sequencing controller.
interface mult_seq_control_if
   import mult_pkg::*;
#(
   parameter int unsigned N_BITS = MULT_N_BITS
) ();

   localparam int unsigned CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   logic          Run_n;
   logic          Clr_Ld_n;
   logic          M;
   op_t           Op;
   logic [CW-1:0] Count;
   logic          Busy;
   logic          Done;

   modport master (
      output Run_n, Clr_Ld_n, M,
      input  Op, Count, Busy, Done
   );

   modport slave (
      input  Run_n, Clr_Ld_n, M,
      output Op, Count, Busy, Done
   );

endinterface

// File: rtl/mult_seq_control_btn_sync.sv
// Two-flop synchronizer for an active-low pushbutton; resets to the released level.
module btn_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mult_seq_control.sv
// Sequencer for the add-shift two's-complement multiplier: one fixed-length run per Run press.
// Optional MULT_SYNC_EN puts a two-flop synchronizer on each pushbutton.
module mult_seq_control
   import mult_pkg::*;
#(
   parameter int unsigned N_BITS = MULT_N_BITS
) (
   input  logic             Clk,
   input  logic             Reset,
   mult_seq_control_if.slave bus
);

   localparam int unsigned   CW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   logic run_n;
   logic clr_ld_n;

`ifdef MULT_SYNC_EN
   btn_sync u_run_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (bus.Run_n),
      .q     (run_n)
   );

   btn_sync u_clr_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (bus.Clr_Ld_n),
      .q     (clr_ld_n)
   );
`else
   assign run_n    = bus.Run_n;
   assign clr_ld_n = bus.Clr_Ld_n;
`endif

   state_t        state_q;
   op_t           op_q;
   logic [CW-1:0] count_q;
   logic          busy_q;
   logic          done_q;
   op_t           op_c;

   // State and registered outputs advance together so every output follows the state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_WAIT_REL;
         op_q    <= OP_HOLD;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_WAIT_REL: begin
               if (run_n && clr_ld_n) begin
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (!clr_ld_n) begin
                  state_q <= S_CLR;
                  op_q    <= OP_CLR_LD;
               end else if (!run_n) begin
                  state_q <= S_START;
                  op_q    <= OP_START;
                  count_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_CLR: begin
               state_q <= S_WAIT_REL;
               op_q    <= OP_HOLD;
            end
            S_START: begin
               state_q <= S_ARITH;
               op_q    <= OP_HOLD;
            end
            S_ARITH: begin
               state_q <= S_SHIFT;
               op_q    <= OP_SHIFT;
            end
            S_SHIFT: begin
               // Count saturates on the last iteration and stays there until the next START.
               if (count_q == LAST) begin
                  state_q <= S_SAVE;
                  op_q    <= OP_SAVE;
               end else begin
                  count_q <= count_q + CW'(1);
                  state_q <= S_ARITH;
                  op_q    <= OP_HOLD;
               end
            end
            S_SAVE: begin
               state_q <= S_HALT;
               op_q    <= OP_HOLD;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            S_HALT: begin
               if (run_n) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_WAIT_REL;
               op_q    <= OP_HOLD;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // ARITH op follows the live multiplier LSB; the final iteration subtracts the sign weight.
   always_comb begin
      op_c = op_q;
      if (state_q == S_ARITH) begin
         if (bus.M) begin
            op_c = (count_q == LAST) ? OP_SUB : OP_ADD;
         end else begin
            op_c = OP_HOLD;
         end
      end
   end

   assign bus.Op    = op_c;
   assign bus.Count = count_q;
   assign bus.Busy  = busy_q;
   assign bus.Done  = done_q;

endmodule

// File: doc/mult_seq_control.md
# mult_seq_control

Sequencing controller for the 8-bit add-shift (two's-complement) multiplier datapath. It turns the active-low Run and Clear/Load pushbuttons into a fixed-length, per-cycle operation stream (`Op`) that drives the XA/B register updates. Per iteration it selects add, subtract or hold from the multiplier LSB `M`. It also debounces "one run per press" and reports progress and completion to the top level.

## Interface
Parameters:
- `N_BITS`, default 8: number of multiplier iterations; `Count` width is $clog2(N_BITS).

Ports:
- `Clk`, input, 1: system clock; all state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Run_n`, input, 1: active-low Run pushbutton (level).
- `Clr_Ld_n`, input, 1: active-low Clear/Load pushbutton (level).
- `M`, input, 1: current multiplier LSB (B[0]) from the datapath.
- `Op`, output, 3: datapath operation for the current cycle.
- `Count`, output, 3: current iteration index, 0..7.
- `Busy`, output, 1: high from START through SAVE inclusive.
- `Done`, output, 1: high in HALT.

## Operation
- Op encoding:
  - CLR_LD = 000
  - HOLD = 001
  - ADD = 010
  - SUB = 011
  - SAVE = 100
  - SHIFT = 101
  - START = 110
- FSM states: WAIT_REL, IDLE, CLR, START, ARITH, SHIFT, SAVE, HALT.
- WAIT_REL (reset state):
  - Op = HOLD.
  - Go to IDLE only when Run_n = 1 and Clr_Ld_n = 1.
- IDLE:
  - Op = HOLD.
  - Clr_Ld_n = 0 → CLR.
  - Else Run_n = 0 → START.
  - Clear has priority on a simultaneous press.
- CLR: Op = CLR_LD for exactly one cycle, then → WAIT_REL.
- START: Op = START (datapath clears XA), Count ← 0, then → ARITH.
- ARITH (Mealy on `M`):
  - M = 0 → Op = HOLD.
  - M = 1 and Count < N_BITS-1 → Op = ADD.
  - M = 1 and Count = N_BITS-1 → Op = SUB.
  - Always → SHIFT.
- SHIFT:
  - Op = SHIFT.
  - If Count = N_BITS-1 → SAVE.
  - Else Count ← Count+1, → ARITH.
- SAVE: Op = SAVE (datapath latches the result), then → HALT.
- HALT:
  - Op = HOLD, Done = 1.
  - Stays until Run_n = 1, then → IDLE. A held Run never starts a second multiply.
- Clr_Ld_n is ignored in START..HALT. Run_n is ignored in START..SAVE.
- `Count` wraps never: it saturates at N_BITS-1 until the next START.

## Timing
- Reset values:
  - state = WAIT_REL
  - Op = HOLD
  - Count = 0
  - Busy = 0
  - Done = 0
- Reset asserted mid-run: outputs take their reset values immediately (asynchronous). After release the FSM waits for both buttons to be released before accepting a new command.
- Run_n sampled low at edge t in IDLE (macro off):
  - START during cycle t+1.
  - ARITH/SHIFT pairs during t+2 .. t+17.
  - SAVE at t+18.
  - Done = 1 from t+19.
- Fixed latency is 18 cycles START→SAVE, independent of `M`.
- `Op` in ARITH is combinational from `M`. All other outputs are decoded from registered state only.

## Configuration
- `MULT_SYNC_EN` defined:
  - Run_n and Clr_Ld_n each pass through a two-flop synchronizer, reset to 1 (released), before the FSM.
  - Every button-to-state latency grows by 2 cycles: START at t+3, Done at t+21.
- `MULT_SYNC_EN` undefined: buttons feed the FSM directly; latencies as in Timing.

## Structure
- Shared package `mult_pkg` holds:
  - `op_t`, the 3-bit Op encoding enum (shared with the datapath `case`).
  - `state_t`, the FSM enum.
  - `MULT_N_BITS` = 8.
- One sub-module: `btn_sync`, a two-flop synchronizer instantiated per button under `MULT_SYNC_EN`.

## Test plan
- Reset held low, then released with both buttons up → Op = HOLD, Busy = 0, Done = 0; IDLE after 1 cycle.
- Clr_Ld_n pulsed low for 5 cycles → Op = CLR_LD for exactly 1 cycle, then HOLD until release and after.
- Run press with M sequence for B = 0x07 (M = 1,1,1,0,0,0,0,0 across iterations) → ARITH ops ADD, ADD, ADD, HOLD×5; SHIFT ×8; SAVE at t+18; Done at t+19.
- Run press with B = 0x80 (M = 1 only at Count = 7) → HOLD×7 then SUB at the last ARITH; SAVE follows.
- Run_n held low through Done for 40 cycles → exactly one START; release → IDLE; second press → second START.
- Reset asserted while Count = 3 → Op = HOLD and Busy = 0 same cycle. With Run still held after release → remains in WAIT_REL, no START until Run is released and pressed again.
